// File: rtl/probe_playback_pkg.sv
// Shared types and field layout for the probe playback engine.
// The 64-bit vector layout matches the capture watcher's probe format.
package probe_playback_pkg;

  localparam int VEC_W    = 64;
  localparam int CTRL_LSB = 0;
  localparam int CTRL_W   = 4;
  localparam int CH_W     = 10;
  localparam int NUM_CH   = 6;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    PLAY,
    DONE
  } state_e;

  // Bit offset of data channel i (1-based).
  function automatic int ch_lsb(input int i);
    return CTRL_W + CH_W * (i - 1);
  endfunction

endpackage

// File: rtl/probe_playback_ram.sv
// Simple dual-port DEPTH x VEC_W table with a registered read port.
// Same-address read and write in one cycle returns the old contents.
module probe_playback_ram
  import probe_playback_pkg::*;
#(
  parameter int  DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [VEC_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [VEC_W-1:0] rd_data
);

  logic [VEC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/probe_playback.sv
// Replays a stored probe-vector table onto drive0..drive6, hold+1 cycles per entry.
// Define PROBE_PLAYBACK_LOOP_EN to honour loop_en (wrap to entry 0 after the last).
module probe_playback
  import probe_playback_pkg::*;
#(
  parameter int  DEPTH  = 256,
  parameter int  HOLD_W = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [VEC_W-1:0]  wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic [AW:0]       length,
  input  logic [HOLD_W-1:0] hold,
  input  logic              loop_en,
  output logic [CTRL_W-1:0] drive0,
  output logic [CH_W-1:0]   drive1,
  output logic [CH_W-1:0]   drive2,
  output logic [CH_W-1:0]   drive3,
  output logic [CH_W-1:0]   drive4,
  output logic [CH_W-1:0]   drive5,
  output logic [CH_W-1:0]   drive6,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [AW:0]       len_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hcnt_q;   // fetch-side cadence, one cycle ahead of the display
  logic [HOLD_W-1:0] dcnt_q;   // display-side cycles of the current entry
  logic [AW-1:0]     faddr_q;  // address of the most recent table read
  logic [AW-1:0]     raddr, next_addr;
  logic              ren, ld_q, accept, running, last_fetch, more, drv_ld;
  logic [VEC_W-1:0]  rd_data, vec_q;

  probe_playback_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (ren),
    .rd_addr (raddr),
    .rd_data (rd_data)
  );

  assign accept     = (state_q == IDLE) && start && !stop;
  assign running    = (state_q == PREFETCH) || (state_q == PLAY);
  assign last_fetch = ({1'b0, faddr_q} == len_q - (AW+1)'(1));
  assign drv_ld     = ld_q && running && !stop;

`ifdef PROBE_PLAYBACK_LOOP_EN
  logic loop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      loop_q <= 1'b0;
    else if (accept) loop_q <= loop_en;
  end

  assign more      = !last_fetch || loop_q;
  assign next_addr = last_fetch ? '0 : faddr_q + AW'(1);
`else
  logic unused_loop_en;
  assign unused_loop_en = loop_en;
  assign more           = !last_fetch;
  assign next_addr      = faddr_q + AW'(1);
`endif

  always_comb begin
    state_d = state_q;
    ren     = 1'b0;
    raddr   = faddr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (length == '0) begin
            state_d = DONE;
          end else begin
            state_d = PREFETCH;
            ren     = 1'b1;
            raddr   = '0;
          end
        end
      end
      PREFETCH, PLAY: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          // Reads lead the display by one cycle so entries change without a bubble.
          if (hcnt_q == hold_q && more) begin
            ren   = 1'b1;
            raddr = next_addr;
          end
          if (state_q == PREFETCH)                  state_d = PLAY;
          else if (dcnt_q == hold_q && !ld_q)       state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      dcnt_q  <= '0;
      faddr_q <= '0;
      ld_q    <= 1'b0;
      vec_q   <= '0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ren;
      valid   <= (state_d == PLAY);
      if (accept) begin
        len_q  <= length;
        hold_q <= hold;
      end
      if (ren) faddr_q <= raddr;
      if (!running)                hcnt_q <= '0;
      else if (hcnt_q == hold_q)   hcnt_q <= '0;
      else                         hcnt_q <= hcnt_q + HOLD_W'(1);
      if (drv_ld) begin
        vec_q  <= rd_data;
        dcnt_q <= '0;
      end else if (state_q == PLAY) begin
        dcnt_q <= dcnt_q + HOLD_W'(1);
      end
    end
  end

  logic [NUM_CH-1:0][CH_W-1:0] ch;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch[i] = vec_q[ch_lsb(i+1) +: CH_W];
  end

  assign drive0 = vec_q[CTRL_LSB +: CTRL_W];
  assign drive1 = ch[0];
  assign drive2 = ch[1];
  assign drive3 = ch[2];
  assign drive4 = ch[3];
  assign drive5 = ch[4];
  assign drive6 = ch[5];
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_probe_playback.sv
// Randomized bench for probe_playback: per-cycle output trace versus a
// table-driven model built from the playback timing rules.
module tb_probe_playback;

  logic        clk, rst_n;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic        start, stop, loop_en;
  logic [8:0]  length;
  logic [15:0] hold;
  logic [3:0]  drive0;
  logic [9:0]  drive1, drive2, drive3, drive4, drive5, drive6;
  logic        valid, busy, done;

  probe_playback dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .length(length), .hold(hold), .loop_en(loop_en),
    .drive0(drive0), .drive1(drive1), .drive2(drive2), .drive3(drive3),
    .drive4(drive4), .drive5(drive5), .drive6(drive6),
    .valid(valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        b;
    logic        d;
    logic [63:0] vec;
  } smp_t;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] tbl [256];
  logic [63:0] last_vec = '0;
  smp_t        exp_q [$];

  function automatic smp_t observe();
    smp_t s;
    s.v   = valid;
    s.b   = busy;
    s.d   = done;
    s.vec = {drive6, drive5, drive4, drive3, drive2, drive1, drive0};
    return s;
  endfunction

  // Expected samples s[1..nsamp], s[k] taken in the cycle after edge N+k-1.
  task automatic build(input int len, input int h, input bit lp, input int stop_at,
                       input int nsamp);
    logic [63:0] cur;
    bit          stopped;
    longint      play_cycles;
    smp_t        s;
    cur     = last_vec;
    stopped = 1'b0;
    play_cycles = lp ? 64'd1 << 40 : longint'(len) * (h + 1);
    exp_q.delete();
    for (int k = 1; k <= nsamp; k++) begin
      s.v = 1'b0; s.b = 1'b0; s.d = 1'b0;
      if (!stopped) begin
        if (len == 0) begin
          s.b = (k == 1); s.d = (k == 1);
        end else if (k == 1) begin
          s.b = 1'b1;
        end else if (longint'(k - 2) < play_cycles) begin
          cur = tbl[((k - 2) / (h + 1)) % len];
          s.v = 1'b1; s.b = 1'b1;
        end else if (longint'(k - 2) == play_cycles) begin
          s.b = 1'b1; s.d = 1'b1;
        end
      end
      s.vec = cur;
      exp_q.push_back(s);
      if (k == stop_at && s.b && !s.d) stopped = 1'b1;
    end
    last_vec = cur;
  endtask

  task automatic load_table();
    for (int i = 0; i < 256; i++) begin
      logic [63:0] v;
      v = {$urandom, $urandom};
      if (i < 4) v[13:4] = 10'(i + 1);
      tbl[i] = v;
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 8'(i); wr_data = v;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    smp_t o;
    o = observe();
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL reset: got v%0b b%0b d%0b %h, want all zero", o.v, o.b, o.d, o.vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One playback run: start, random parameter churn, optional stop / extra start.
  task automatic test_play(input string name, input int len, input int h, input bit lp_req,
                           input int stop_in, input int start_at);
    bit   lp;
    int   stop_at, nsamp;
    smp_t o, e;
`ifdef PROBE_PLAYBACK_LOOP_EN
    lp = lp_req;
`else
    lp = 1'b0;
`endif
    stop_at = stop_in;
    if (lp && stop_at < 0) stop_at = 2 + len * (h + 1) + 3;
    nsamp = (stop_at > 0) ? stop_at + 2 : 2 + len * (h + 1) + 2;
    build(len, h, lp, stop_at, nsamp);
    @(negedge clk);
    start = 1'b1; length = 9'(len); hold = 16'(h); loop_en = lp_req;
    @(negedge clk);
    start = 1'b0; length = 9'($urandom); hold = 16'($urandom); loop_en = 1'($urandom);
    for (int k = 1; k <= nsamp; k++) begin
      o = observe();
      e = exp_q[k-1];
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s s%0d: got v%0b b%0b d%0b %h, want v%0b b%0b d%0b %h",
                 name, k, o.v, o.b, o.d, o.vec, e.v, e.b, e.d, e.vec);
      end
      stop  = (k == stop_at);
      start = (k == start_at) && e.b;
      if (start) length = 9'($urandom_range(1, 8));
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_start_stop_idle();
    smp_t o;
    @(negedge clk);
    start = 1'b1; stop = 1'b1; length = 9'd3; hold = 16'd0;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      o = observe();
      total++;
      if (o.v !== 1'b0 || o.b !== 1'b0 || o.d !== 1'b0 || o.vec !== last_vec) begin
        bad++;
        $display("FAIL start_stop_idle s%0d: got v%0b b%0b d%0b %h, want idle %h",
                 k, o.v, o.b, o.d, o.vec, last_vec);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    smp_t o;
    @(negedge clk);
    start = 1'b1; length = 9'd4; hold = 16'd1; loop_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    o = observe();
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL reset_mid: got v%0b b%0b d%0b %h, want all zero", o.v, o.b, o.d, o.vec);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    last_vec = '0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; length = '0; hold = '0; loop_en = 1'b0;
    #12;
    test_reset();
    load_table();
    test_play("load_play", 4, 0, 1'b0, -1, -1);
    test_play("hold",      4, 2, 1'b0, -1, -1);
    test_play("loop",      2, 0, 1'b1,  6, -1);
    test_play("len0",      0, 0, 1'b0, -1, -1);
    test_start_stop_idle();
    test_play("start_in_play", 4, 1, 1'b0, -1, 4);
    test_play("stop_prefetch", 3, 0, 1'b0,  1, -1);
    test_play("full_depth", 256, 0, 1'b0, -1, -1);
    test_reset_mid();
    test_play("replay",    4, 0, 1'b0, -1, -1);
    for (int r = 0; r < 10; r++) begin
      int len, h, sa, st;
      bit lp;
      len = $urandom_range(1, 6);
      h   = $urandom_range(0, 3);
      lp  = 1'($urandom);
      sa  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 + len * (h + 1)) : -1;
      st  = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 1 + len * (h + 1)) : -1;
      test_play("random", len, h, lp, sa, st);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
